// File: rtl/fmul_pkg.sv
// Shared types and widths for the half-precision multiplier scheduler.
package fmul_pkg;

    localparam int HP_W      = 16;
    localparam int OVF_CNT_W = 8;
    localparam int ID_MAX_W  = 3;

    typedef struct packed {
        logic [HP_W-1:0] a;
        logic [HP_W-1:0] b;
    } operand_t;

    typedef struct packed {
        logic [HP_W-1:0]     data;
        logic                ovf;
        logic [ID_MAX_W-1:0] id;
    } resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority select: first set request at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id
);

    always_comb begin
        int unsigned idx;
        logic        found;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant_id   = IDW'(idx);
                grant[idx] = en;
            end
        end
    end

endmodule

// File: rtl/fmul_sched.sv
// Shares one external combinational half-precision multiplier among NREQ requesters
// through an operand register stage and a response register stage.
module fmul_sched
    import fmul_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*HP_W-1:0] req_a,
    input  logic [NREQ*HP_W-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [HP_W-1:0]      mul_a,
    output logic [HP_W-1:0]      mul_b,
    input  logic [HP_W-1:0]      mul_result,
    input  logic                 mul_overflow,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [HP_W-1:0]      resp_data,
    output logic                 resp_ovf,
    output logic [IDW-1:0]       resp_id,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    logic           op_valid;
    logic [IDW-1:0] op_id;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] grant_id;
    logic           adv_a;
    logic           adv_r;
    logic           arb_en;
    logic           xfer;
    operand_t       win;

    assign adv_r  = op_valid & (~resp_valid | resp_ready);
    assign adv_a  = ~op_valid | adv_r;
    // rst gating keeps req_ready low for the whole reset pulse, not just after the first edge
    assign arb_en = adv_a & ~rst;
    assign xfer   = |(req_valid & req_ready);

    rr_arbiter #(
        .NREQ(NREQ),
        .IDW (IDW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .en      (arb_en),
        .grant   (req_ready),
        .grant_id(grant_id)
    );

    always_comb begin
        win = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                win.a = req_a[i*HP_W +: HP_W];
                win.b = req_b[i*HP_W +: HP_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_valid <= 1'b0;
            op_id    <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            ptr      <= '0;
        end else if (xfer) begin
            op_valid <= 1'b1;
            op_id    <= grant_id;
            mul_a    <= win.a;
            mul_b    <= win.b;
            ptr      <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
        end else if (adv_a) begin
            op_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_ovf   <= 1'b0;
            resp_id    <= '0;
        end else if (adv_r) begin
            resp_valid <= 1'b1;
            resp_data  <= mul_result;
            resp_ovf   <= mul_overflow;
            resp_id    <= op_id;
        end else if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (resp_valid && resp_ready && resp_ovf && !(&ovf_count)) begin
            ovf_count <= ovf_count + OVF_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fmul_sched.sv
// Directed bench for fmul_sched with a stub multiplier, an occupancy/arbiter model and a response scoreboard.
module tb_fmul_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_ready;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [15:0] mul_result;
    logic        mul_overflow;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;
    logic        resp_ovf;
    logic [1:0]  resp_id;
    logic [7:0]  ovf_count;

    typedef struct {
        logic [15:0] data;
        logic        ovf;
        logic [1:0]  id;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   accepted = 0;
    int   mptr = 0;
    int   mcnt = 0;
    logic opv = 1'b0;
    logic rv = 1'b0;

    assign mul_result   = mul_a ^ mul_b;
    assign mul_overflow = mul_a[15];

    fmul_sched #(
        .NREQ(4),
        .IDW (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_result  (mul_result),
        .mul_overflow(mul_overflow),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_ovf    (resp_ovf),
        .resp_id     (resp_id),
        .ovf_count   (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic settle();
        #2;
    endtask

    // One clock: check and update the model at the negedge, return at posedge+1.
    task automatic tick();
        logic [3:0] er;
        logic       found;
        logic       ar;
        logic       aa;
        int         w;
        exp_t       e;
        @(negedge clk);
        ar    = opv & (!rv | resp_ready);
        aa    = !opv | ar;
        found = 1'b0;
        w     = 0;
        er    = '0;
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (mptr + k) % 4;
            if (!found && req_valid[j]) begin
                found = 1'b1;
                w     = j;
            end
        end
        if (found && aa && !rst) er[w] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("resp_valid", 32'(resp_valid), 32'(rv));
        chk("ovf_count", 32'(ovf_count), 32'(mcnt));
        if (resp_valid && resp_ready) begin
            tests++;
            assert (q.size() != 0)
            else begin
                fails++;
                $error("FAIL sb_extra observed=response expected=none id=%0d", resp_id);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("resp_data", 32'(resp_data), 32'(e.data));
                chk("resp_ovf", 32'(resp_ovf), 32'(e.ovf));
                chk("resp_id", 32'(resp_id), 32'(e.id));
                if (e.ovf && mcnt < 255) mcnt++;
            end
        end
        if (er != 4'b0) begin
            e.data = req_a[16*w +: 16] ^ req_b[16*w +: 16];
            e.ovf  = req_a[16*w + 15];
            e.id   = 2'(w);
            q.push_back(e);
            opv  = 1'b1;
            mptr = (w + 1) % 4;
            accepted++;
        end else if (aa) begin
            opv = 1'b0;
        end
        if (ar) rv = 1'b1;
        else if (rv && resp_ready) rv = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 20; k++) begin
            if (q.size() == 0 && !opv && !rv) break;
            tick();
        end
        chk("drain_done", 32'(q.size() == 0 && !opv && !rv), 32'd1);
    endtask

    logic [15:0] held_a;
    logic [15:0] held_b;

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        chk("rst_ovf_count", 32'(ovf_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fairness: all valid, grants rotate 0,1,2,3,...
        req_valid = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < 4; i++) set_op(i, 16'($urandom) & 16'h7FFF, 16'($urandom));
            settle();
            chk("fair_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            tick();
        end
        req_valid = '0;
        drain();

        // Single request from requester 2
        set_op(2, 16'h3C00, 16'h4000);
        req_valid = 4'b0100;
        settle();
        chk("single_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        tick();
        chk("single_valid", 32'(resp_valid), 32'd1);
        chk("single_data", 32'(resp_data), 32'h7C00);
        chk("single_ovf", 32'(resp_ovf), 32'd0);
        chk("single_id", 32'(resp_id), 32'd2);
        drain();

        // Pointer wrap: 3 then 0
        set_op(3, 16'h1234, 16'h00FF);
        set_op(0, 16'h0F0F, 16'h0101);
        req_valid = 4'b1000;
        settle();
        chk("wrap_grant3", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0001;
        settle();
        chk("wrap_grant0", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        drain();

        // Backpressure: ids 0 and 1 accepted, then consumer stalls
        resp_ready = 1'b0;
        set_op(0, 16'h1111, 16'h0001);
        set_op(1, 16'h2222, 16'h0002);
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1111;
        settle();
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        held_a = mul_a;
        held_b = mul_b;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_resp_id", 32'(resp_id), 32'd0);
            chk("bp_mul_a", 32'(mul_a), 32'(held_a));
            chk("bp_mul_b", 32'(mul_b), 32'(held_b));
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        drain();

        // Overflow counter saturation
        for (int i = 0; i < 4; i++) set_op(i, 16'h8001, 16'h0001);
        accepted  = 0;
        req_valid = 4'b1111;
        for (int k = 0; k < 400; k++) begin
            if (accepted >= 300) break;
            tick();
        end
        chk("ovf_accepted", 32'(accepted), 32'd300);
        req_valid = '0;
        drain();
        chk("ovf_saturated", 32'(ovf_count), 32'd255);
        chk("ovf_data", 32'(resp_data), 32'h8000);
        chk("ovf_flag", 32'(resp_ovf), 32'd1);

        // Reset one cycle after a handshake
        set_op(1, 16'hABCD, 16'h1357);
        req_valid = 4'b0010;
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_mul_a", 32'(mul_a), 32'd0);
        chk("mid_rst_mul_b", 32'(mul_b), 32'd0);
        chk("mid_rst_resp_data", 32'(resp_data), 32'd0);
        chk("mid_rst_resp_ovf", 32'(resp_ovf), 32'd0);
        chk("mid_rst_resp_id", 32'(resp_id), 32'd0);
        chk("mid_rst_ovf_count", 32'(ovf_count), 32'd0);
        q.delete();
        opv  = 1'b0;
        rv   = 1'b0;
        mptr = 0;
        mcnt = 0;
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("post_rst_idle", 32'(resp_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fmul_sched.md
# fmul_sched

Round-robin scheduler that shares one external combinational half-precision multiplier among `NREQ` requesters. It accepts operand pairs through per-requester valid/ready handshakes and registers the winning operands into the multiplier's inputs. It captures the product, overflow flag and requester id into an output register with its own valid/ready handshake. It sits between the vector/control front-ends and the single multiplier instance, so one multiplier serves all requesters at up to one operation per cycle.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, 2: requester id width, ≥ clog2(NREQ).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in NREQ: bit i = requester i has an operand pair.
- `req_a`, `req_b` in NREQ*16: packed operands, requester i at [16i+15:16i].
- `req_ready` out NREQ: one-hot grant; transfer on `req_valid[i] & req_ready[i]`.
- `mul_a`, `mul_b` out 16: registered operands to the multiplier.
- `mul_result` in 16: multiplier product, combinational from `mul_a`/`mul_b`.
- `mul_overflow` in 1: multiplier overflow flag.
- `resp_valid` out 1: response register holds a result.
- `resp_ready` in 1: consumer accepts the response.
- `resp_data` out 16: captured product.
- `resp_ovf` out 1: captured overflow.
- `resp_id` out IDW: requester that issued the operation.
- `ovf_count` out 8: saturating count of responses delivered with `resp_ovf=1`.

## Operation
- Two register stages:
  - Stage A: `op_valid`, `mul_a`, `mul_b`, `op_id`.
  - Stage R: `resp_valid`, `resp_data`, `resp_ovf`, `resp_id`.
- Stage R advance: `adv_r = op_valid & (~resp_valid | resp_ready)`.
  - On `adv_r`, stage R loads `mul_result`, `mul_overflow`, `op_id` and sets `resp_valid`.
  - Otherwise `resp_valid` clears on `resp_valid & resp_ready`.
- Stage A advance: `adv_a = ~op_valid | adv_r`.
- Arbitration is combinational.
  - Scan `req_valid` starting at pointer `ptr`, wrapping modulo NREQ.
  - The first set bit wins.
  - `req_ready` is one-hot on the winner only when `adv_a`, else all zero.
- On a transfer:
  - Stage A loads the winner's operands and id, and `op_valid` is set.
  - `ptr` becomes winner+1 mod NREQ.
- Without a transfer:
  - `op_valid` clears on `adv_a`; otherwise stage A holds.
  - `ptr` holds.
- `req_ready` never depends on `req_valid` of other requesters beyond priority selection. No requester waits more than NREQ-1 grants.
- `ovf_count` increments on `resp_valid & resp_ready & resp_ovf`. It saturates at 255 and never wraps.
- Operands and results pass through bit-exact; the block does no arithmetic on data.

## Timing
- Reset values (async assert, released synchronously to `clk`):
  - `op_valid=0`, `resp_valid=0`, `ptr=0`.
  - `mul_a=mul_b=0`, `resp_data=0`, `resp_ovf=0`, `resp_id=0`, `ovf_count=0`.
  - `req_ready=0` while `rst` is high.
- Latency: a request accepted at edge N gives `resp_valid=1` after edge N+1, i.e. 2 cycles from handshake to response, when not stalled.
- Throughput: one result per cycle with `resp_ready` held high.
- Full stall: `resp_valid & ~resp_ready` with `op_valid=1`.
  - `req_ready=0`, and both stages hold.
  - `mul_a`/`mul_b` must stay stable.
- Simultaneous response pop and new capture in one cycle is legal. There is no bubble.
- Reset asserted mid-operation discards in-flight operations. No response for them appears after reset.
- A requester may drop `req_valid` before a grant. Data is only sampled at the handshake.

## Structure
- Shared package `fmul_pkg`:
  - `HP_W=16`.
  - Packed operand-pair type (`a`, `b`).
  - Response struct (`data`, `ovf`, `id`).
  - `OVF_CNT_W=8`.
- One sub-module: `rr_arbiter` (NREQ-wide).
  - Inputs: `req`, `ptr`, `en`.
  - Outputs: `grant` (one-hot), `grant_id`.
  - Pointer register lives in `fmul_sched`.
- The multiplier stays outside the block.

## Test plan
Bench uses a stub multiplier: `mul_result = mul_a ^ mul_b`, `mul_overflow = mul_a[15]`.
- Single request:
  - Stimulus: `rst` released, requester 2 sends a=0x3C00, b=0x4000, `resp_ready=1`.
  - Required: `req_ready=4'b0100` in the handshake cycle; 2 cycles later `resp_valid=1`, `resp_data=0x7C00`, `resp_ovf=0`, `resp_id=2`.
- Fairness:
  - Stimulus: all 4 requesters valid continuously, `resp_ready=1`.
  - Required: grants 0,1,2,3,0,… one per cycle; `resp_id` follows the same order.
- Backpressure:
  - Stimulus: requests 0 and 1 accepted, then `resp_ready=0` for 5 cycles.
  - Required: `req_ready=0` once both stages are full; `resp_id=0` held stable; after release, ids 0 then 1 with no loss or duplication.
- Overflow counter:
  - Stimulus: 300 accepted responses with a=0x8001, b=0x0001.
  - Required: `resp_data=0x8000`, `resp_ovf=1`; `ovf_count` saturates at 255.
- Reset mid-flight:
  - Stimulus: assert `rst` 1 cycle after a handshake.
  - Required: all outputs at reset values immediately; no `resp_valid` after release.
- Pointer wrap:
  - Stimulus: only requester 3 valid, then only requester 0.
  - Required: `ptr` wraps to 0; requester 0 is granted on the first cycle after.
